// File: rtl/bram_fifo_arbiter.sv
// bram_fifo_arbiter: round-robin sharing of BRAM FIFO read/write ports between op loader and op reader
module bram_fifo_arbiter #(
  parameter int MAX_ROWS = 621,
  parameter int PRELOADED_ROWS = 0,
  parameter int LEVEL_BITS = $clog2(MAX_ROWS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  wr_trigger,
  output logic                  wr_rdy,
  output logic                  wr_done,
  input  logic                  rd_trigger,
  output logic                  rd_rdy,
  output logic                  rd_done,
  output logic                  fifo_wr_trigger,
  input  logic                  fifo_wr_done,
  input  logic                  fifo_wr_rdy,
  output logic                  fifo_rd_trigger,
  input  logic                  fifo_rd_done,
  input  logic                  fifo_rd_rdy,
  input  logic                  is_full,
  input  logic                  is_empty,
  output logic [LEVEL_BITS-1:0] level,
  output logic                  level_err
);
  typedef enum logic [2:0] {IDLE, ISSUE_WR, WAIT_WR, ISSUE_RD, WAIT_RD} state_t;
  localparam logic [LEVEL_BITS-1:0] MAXL = LEVEL_BITS'(MAX_ROWS);
  localparam logic [LEVEL_BITS-1:0] PREL = LEVEL_BITS'(PRELOADED_ROWS);
  state_t state_q;
  logic pend_wr_q, pend_rd_q, last_wr_q, wr_done_q, rd_done_q, fwt_q, frt_q, err_q;
  logic [LEVEL_BITS-1:0] level_q;
  logic wr_el, rd_el, pick_wr;
  assign wr_el = pend_wr_q & ~is_full & fifo_wr_rdy;
  assign rd_el = pend_rd_q & ~is_empty & fifo_rd_rdy;
  assign pick_wr = wr_el & (~rd_el | ~last_wr_q);
  // request latches, arbitration FSM and saturating fill level
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pend_wr_q <= 1'b0;
      pend_rd_q <= 1'b0;
      last_wr_q <= 1'b0;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
      fwt_q     <= 1'b0;
      frt_q     <= 1'b0;
      err_q     <= 1'b0;
      level_q   <= PREL;
    end else if (clk_en) begin
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
      fwt_q     <= 1'b0;
      frt_q     <= 1'b0;
      if (wr_trigger && !pend_wr_q) pend_wr_q <= 1'b1;
      if (rd_trigger && !pend_rd_q) pend_rd_q <= 1'b1;
      case (state_q)
        IDLE: if (wr_el || rd_el) begin
          state_q <= pick_wr ? ISSUE_WR : ISSUE_RD;
          fwt_q   <= pick_wr;
          frt_q   <= !pick_wr;
        end
        ISSUE_WR: begin
          last_wr_q <= 1'b1;
          state_q   <= WAIT_WR;
        end
        ISSUE_RD: begin
          last_wr_q <= 1'b0;
          state_q   <= WAIT_RD;
        end
        WAIT_WR: if (fifo_wr_done) begin
          pend_wr_q <= 1'b0;
          wr_done_q <= 1'b1;
          state_q   <= IDLE;
          err_q     <= err_q | (level_q == MAXL);
          level_q   <= (level_q == MAXL) ? level_q : level_q + 1'b1;
        end
        WAIT_RD: if (fifo_rd_done) begin
          pend_rd_q <= 1'b0;
          rd_done_q <= 1'b1;
          state_q   <= IDLE;
          err_q     <= err_q | (level_q == '0);
          level_q   <= (level_q == '0) ? level_q : level_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign wr_rdy          = ~pend_wr_q;
  assign rd_rdy          = ~pend_rd_q;
  assign wr_done         = wr_done_q;
  assign rd_done         = rd_done_q;
  assign fifo_wr_trigger = fwt_q;
  assign fifo_rd_trigger = frt_q;
  assign level           = level_q;
  assign level_err       = err_q;
endmodule

// File: tb/tb_bram_fifo_arbiter.sv
// tb_bram_fifo_arbiter: directed and random checks of the arbiter against a transaction-level model
module tb_bram_fifo_arbiter;
  localparam int MAX = 6;
  localparam int PRE = 3;
  localparam int LB = $clog2(MAX + 1);
  logic clk = 1'b0, reset, clk_en, wr_trigger, rd_trigger;
  logic fifo_wr_done, fifo_wr_rdy, fifo_rd_done, fifo_rd_rdy, is_full, is_empty;
  logic wr_rdy, wr_done, rd_rdy, rd_done, fifo_wr_trigger, fifo_rd_trigger, level_err;
  logic [LB-1:0] level;
  int total = 0, bad = 0, cyc_n = 0;
  int e_lvl, wt, rt, wlat, rlat, fcnt, full_ovr, empty_ovr, wtrig_cyc, n0;
  bit e_err, pend_w, pend_r, e_wd, e_rd, out_w, out_r;
  byte grants[$];

  bram_fifo_arbiter #(.MAX_ROWS(MAX), .PRELOADED_ROWS(PRE)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .wr_trigger(wr_trigger), .wr_rdy(wr_rdy), .wr_done(wr_done),
    .rd_trigger(rd_trigger), .rd_rdy(rd_rdy), .rd_done(rd_done),
    .fifo_wr_trigger(fifo_wr_trigger), .fifo_wr_done(fifo_wr_done), .fifo_wr_rdy(fifo_wr_rdy),
    .fifo_rd_trigger(fifo_rd_trigger), .fifo_rd_done(fifo_rd_done), .fifo_rd_rdy(fifo_rd_rdy),
    .is_full(is_full), .is_empty(is_empty), .level(level), .level_err(level_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic upd_flags();
    is_full  = full_ovr == 1 ? 1'b1 : full_ovr == 2 ? 1'b0 : (fcnt >= MAX);
    is_empty = empty_ovr == 1 ? 1'b1 : empty_ovr == 2 ? 1'b0 : (fcnt <= 0);
  endtask

  // one clock: sample inputs at the edge, advance the transaction model, check outputs
  task automatic cyc();
    bit en, rs, wts, rts, fwd, frd, fs, es;
    en = clk_en; rs = reset; wts = wr_trigger; rts = rd_trigger;
    fwd = fifo_wr_done; frd = fifo_rd_done; fs = is_full; es = is_empty;
    @(posedge clk);
    #1;
    cyc_n++;
    if (rs) begin
      e_lvl = PRE; e_err = 0; pend_w = 0; pend_r = 0; e_wd = 0; e_rd = 0;
      out_w = 0; out_r = 0; wt = 0; rt = 0; fifo_wr_done = 0; fifo_rd_done = 0;
      chk("rst_fifo_wr_trigger", fifo_wr_trigger, 0);
      chk("rst_fifo_rd_trigger", fifo_rd_trigger, 0);
    end else if (en) begin
      if (wts && !pend_w) pend_w = 1;
      if (rts && !pend_r) pend_r = 1;
      e_wd = fwd && out_w;
      e_rd = frd && out_r;
      if (e_wd) begin
        pend_w = 0; out_w = 0;
        if (e_lvl == MAX) e_err = 1; else e_lvl++;
      end
      if (e_rd) begin
        pend_r = 0; out_r = 0;
        if (e_lvl == 0) e_err = 1; else e_lvl--;
      end
      fifo_wr_done = 0;
      fifo_rd_done = 0;
      if (wt > 0) begin
        wt--;
        if (wt == 0) begin fifo_wr_done = 1; fcnt++; end
      end
      if (rt > 0) begin
        rt--;
        if (rt == 0) begin fifo_rd_done = 1; if (fcnt > 0) fcnt--; end
      end
      chk("both_fifo_triggers", fifo_wr_trigger && fifo_rd_trigger, 0);
      if (fifo_wr_trigger) begin
        chk("wr_issue_while_full", fs, 0);
        grants.push_back("W"); out_w = 1; wt = wlat; wtrig_cyc = cyc_n;
      end
      if (fifo_rd_trigger) begin
        chk("rd_issue_while_empty", es, 0);
        grants.push_back("R"); out_r = 1; rt = rlat;
      end
    end
    chk("wr_done", wr_done, e_wd);
    chk("rd_done", rd_done, e_rd);
    chk("level", level, e_lvl);
    chk("level_err", level_err, e_err);
    chk("wr_rdy", wr_rdy, !pend_w);
    chk("rd_rdy", rd_rdy, !pend_r);
    upd_flags();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((pend_w || pend_r || out_w || out_r || e_wd || e_rd) && n < budget) begin
      cyc();
      n++;
    end
    if (pend_w || pend_r || out_w || out_r || e_wd || e_rd) begin
      total++; bad++;
      $error("FAIL idle_timeout observed=busy expected=idle within %0d cycles", budget);
    end
  endtask

  task automatic do_reset();
    reset = 1; cyc(); reset = 0; fcnt = PRE; upd_flags(); grants.delete();
  endtask

  task automatic do_wr();
    wr_trigger = 1; cyc(); wr_trigger = 0; wait_idle(60);
  endtask

  task automatic do_rd();
    rd_trigger = 1; cyc(); rd_trigger = 0; wait_idle(60);
  endtask

  task automatic chk_grants(input string tag, input string exp);
    chk({tag, "_count"}, grants.size(), exp.len());
    for (int i = 0; i < exp.len() && i < grants.size(); i++) chk(tag, grants[i], exp[i]);
  endtask

  initial begin
    reset = 1; clk_en = 1; wr_trigger = 0; rd_trigger = 0;
    fifo_wr_done = 0; fifo_rd_done = 0; fifo_wr_rdy = 1; fifo_rd_rdy = 1;
    wlat = 2; rlat = 2; fcnt = PRE; full_ovr = 0; empty_ovr = 0; wtrig_cyc = -1;
    upd_flags();
    cyc(); cyc();
    reset = 0;
    chk("t1_level", level, PRE);
    chk("t1_wr_rdy", wr_rdy, 1);
    chk("t1_rd_rdy", rd_rdy, 1);
    chk("t1_level_err", level_err, 0);
    cyc();
    chk_grants("t1_no_grant", "");

    wlat = 4; n0 = cyc_n;
    wr_trigger = 1; cyc(); wr_trigger = 0;
    chk("t2_wr_rdy_low", wr_rdy, 0);
    wait_idle(40);
    chk("t2_latency", wtrig_cyc, n0 + 2);
    chk("t2_level", level, PRE + 1);
    chk_grants("t2_grants", "W");
    wlat = 2;

    do_reset();
    for (int r = 0; r < 3; r++) begin
      wr_trigger = 1; rd_trigger = 1; cyc(); wr_trigger = 0; rd_trigger = 0;
      wait_idle(60);
    end
    chk_grants("t3_grants", "WRWRWR");
    chk("t3_level", level, PRE);

    repeat (PRE) do_rd();
    chk("t4_drained", level, 0);
    grants.delete();
    rd_trigger = 1; cyc(); rd_trigger = 0;
    repeat (6) cyc();
    chk_grants("t4_held", "");
    chk("t4_rd_pending", rd_rdy, 0);
    do_wr();
    chk_grants("t4_grants", "WR");
    chk("t4_level", level, 0);

    do_wr();
    full_ovr = 1; upd_flags(); grants.delete();
    wr_trigger = 1; rd_trigger = 1; cyc(); wr_trigger = 0; rd_trigger = 0;
    repeat (8) cyc();
    chk_grants("t5_read_first", "R");
    chk("t5_wr_held", wr_rdy, 0);
    full_ovr = 0; upd_flags();
    wait_idle(60);
    chk_grants("t5_grants", "RW");
    chk("t5_level", level, 1);

    do_reset();
    repeat (MAX - PRE) do_wr();
    chk("ovf_full_level", level, MAX);
    full_ovr = 2; upd_flags();
    do_wr();
    chk("ovf_level", level, MAX);
    chk("ovf_err", level_err, 1);
    full_ovr = 0;

    do_reset();
    rlat = 6;
    rd_trigger = 1; cyc(); rd_trigger = 0;
    for (int i = 0; i < 10 && !out_r; i++) cyc();
    chk("t6_in_wait", out_r, 1);
    cyc();
    reset = 1; cyc(); reset = 0;
    fifo_rd_done = 1; cyc();
    cyc();
    chk("t6_no_rd_done", rd_done, 0);
    chk("t6_level", level, PRE);
    rlat = 2;
    repeat (PRE) do_rd();
    empty_ovr = 2; upd_flags();
    do_rd();
    chk("t6_sat_level", level, 0);
    chk("t6_sat_err", level_err, 1);
    empty_ovr = 0;

    do_reset();
    for (int i = 0; i < 600; i++) begin
      wr_trigger = $urandom_range(0, 3) == 0;
      rd_trigger = $urandom_range(0, 3) == 0;
      clk_en = $urandom_range(0, 7) != 0;
      wlat = $urandom_range(1, 4);
      rlat = $urandom_range(1, 4);
      cyc();
    end
    clk_en = 1; wr_trigger = 0; rd_trigger = 0;
    wait_idle(80);
    chk("rnd_level_vs_fifo", level, fcnt);
    chk("rnd_no_err", level_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
